// File: rtl/imm_encoder.sv
// Immediate-field encoder for RV32 instruction templates, plus li-style
// expansion of a 32-bit constant into LUI/ADDI with a one-word output register.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic        li_mode,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HI_W = 20;
    localparam int unsigned LO_W = 12;

    localparam logic [2:0] TYPE_R = 3'b000;
    localparam logic [2:0] TYPE_I = 3'b001;
    localparam logic [2:0] TYPE_S = 3'b010;
    localparam logic [2:0] TYPE_B = 3'b011;
    localparam logic [2:0] TYPE_U = 3'b100;
    localparam logic [2:0] TYPE_J = 3'b101;

    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state;
    logic [XLEN-1:0]   pend_instr;

    logic [LO_W-1:0]   lo;
    logic [HI_W-1:0]   hi;
    logic [XLEN-1:0]   lui_word;
    logic [XLEN-1:0]   addi_rd_word;
    logic [XLEN-1:0]   addi_x0_word;
    logic [XLEN-1:0]   enc_instr;
    logic              enc_err;
    logic              enc_last;
    logic              enc_two;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    // First (or only) word for the request currently on the input.
    always_comb begin
        lo           = imm[11:0];
        hi           = imm[31:12] + HI_W'(imm[11]);
        lui_word     = {hi, rd, OPC_LUI};
        addi_rd_word = {lo, rd, 3'b000, rd, OPC_ADDI};
        addi_x0_word = {lo, 5'd0, 3'b000, rd, OPC_ADDI};
        enc_instr    = base;
        enc_err      = 1'b0;
        enc_last     = 1'b1;
        enc_two      = 1'b0;

        if (li_mode) begin
            // The +imm[11] carry compensates for ADDI sign-extending lo.
            if (hi != '0) begin
                enc_instr = lui_word;
                if (lo != '0) begin
                    enc_two  = 1'b1;
                    enc_last = 1'b0;
                end
            end else begin
                enc_instr = addi_x0_word;
            end
        end else begin
            case (imm_type)
                TYPE_R: begin
                    enc_instr = base;
                end
                TYPE_I: begin
                    enc_instr = {imm[11:0], base[19:0]};
                    enc_err   = (imm[31:12] != {20{imm[11]}});
                end
                TYPE_S: begin
                    enc_instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                    enc_err   = (imm[31:12] != {20{imm[11]}});
                end
                TYPE_B: begin
                    enc_instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                    enc_err   = (imm[31:13] != {19{imm[12]}}) || imm[0];
                end
                TYPE_U: begin
                    enc_instr = {imm[31:12], base[11:0]};
                    enc_err   = (imm[11:0] != '0);
                end
                TYPE_J: begin
                    enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                    enc_err   = (imm[31:21] != {11{imm[20]}}) || imm[0];
                end
                default: begin
                    enc_instr = base;
                    enc_err   = 1'b1;
                end
            endcase
        end
    end

    // Output register and li sequencing; reset drops any pending ADDI word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            out_last   <= 1'b0;
            pend_instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        out_valid <= 1'b1;
                        out_instr <= enc_instr;
                        out_err   <= enc_err;
                        out_last  <= enc_last;
                        if (enc_two) begin
                            state      <= SECOND;
                            pend_instr <= addi_rd_word;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SECOND: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        out_instr <= pend_instr;
                        out_err   <= 1'b0;
                        out_last  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases plus randomized traffic scored against
// an arithmetic reference model of the expected output word stream.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] base;
    logic [31:0] imm;
    logic        li_mode;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .base(base), .imm(imm), .li_mode(li_mode), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_last(out_last)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } word_t;

    word_t       q[$];
    int          checks = 0;
    int          errors = 0;
    bit          stall_prev = 1'b0;
    word_t       held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected words for one accepted request, derived from value ranges and field masks.
    function automatic void model(input bit li, input logic [2:0] t, input logic [31:0] b,
                                  input logic [31:0] v, input logic [4:0] r);
        int signed   s;
        logic [31:0] w;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          e;
        s = $signed(v);
        e = 1'b0;
        if (li) begin
            hi = (v + 32'h800) >> 12;
            lo = v & 32'hFFF;
            if (hi != 0) begin
                w = (hi << 12) | (32'(r) << 7) | 32'h37;
                q.push_back('{w, 1'b0, lo == 0});
                if (lo != 0)
                    q.push_back('{(lo << 20) | (32'(r) << 15) | (32'(r) << 7) | 32'h13, 1'b0, 1'b1});
            end else begin
                q.push_back('{(lo << 20) | (32'(r) << 7) | 32'h13, 1'b0, 1'b1});
            end
            return;
        end
        case (t)
            3'd0: w = b;
            3'd1: begin
                w = (b & 32'h000FFFFF) | (v << 20);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                w = (b & 32'h01FFF07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd3: begin
                w = (b & 32'h01FFF07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
                  | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
                e = !(s >= -4096 && s <= 4095) || (v % 2 != 0);
            end
            3'd4: begin
                w = (b & 32'hFFF) | (v & 32'hFFFFF000);
                e = (v & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (b & 32'hFFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                  | (((v >> 11) & 32'h1) << 20) | (v & 32'h000FF000);
                e = !(s >= -(1 << 20) && s < (1 << 20)) || (v % 2 != 0);
            end
            default: begin
                w = b;
                e = 1'b1;
            end
        endcase
        q.push_back('{w, e, 1'b1});
    endfunction

    // One clock cycle with inputs already driven: score handshakes, then advance.
    task automatic cyc();
        word_t x;
        #1;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || (q.size() == 1 && out_ready)));
            if (stall_prev) begin
                chk("hold_instr", out_instr, held.instr);
                chk("hold_err", 32'(out_err), 32'(held.err));
                chk("hold_last", 32'(out_last), 32'(held.last));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                x = q.pop_front();
                chk("word_instr", out_instr, x.instr);
                chk("word_err", 32'(out_err), 32'(x.err));
                chk("word_last", 32'(out_last), 32'(x.last));
            end
            if (in_valid && in_ready) model(li_mode, imm_type, base, imm, rd);
            stall_prev = out_valid && !out_ready;
            held = '{out_instr, out_err, out_last};
        end
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic [31:0] ei, input bit ee, input bit el);
        #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".instr"}, out_instr, ei);
        chk({tag, ".err"}, 32'(out_err), 32'(ee));
        chk({tag, ".last"}, 32'(out_last), 32'(el));
    endtask

    task automatic req(input bit li, input logic [2:0] t, input logic [31:0] b,
                       input logic [31:0] v, input logic [4:0] r);
        in_valid = 1'b1;
        li_mode  = li;
        imm_type = t;
        base     = b;
        imm      = v;
        rd       = r;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; imm_type = '0; base = '0; imm = '0;
        li_mode = 1'b0; rd = '0; out_ready = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        chk("rst.last", 32'(out_last), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        cyc();

        out_ready = 1'b1;
        req(0, 3'd1, 32'h00008093, 32'hFFFFFFFF, 5'd0); cyc();
        in_valid = 1'b0; lit("i_neg1", 32'hFFF08093, 0, 1); cyc();

        req(0, 3'd3, 32'h00000063, 32'hFFFFFFFE, 5'd0); cyc();
        req(0, 3'd3, 32'h00000063, 32'h00000801, 5'd0);
        lit("b_neg2", 32'hFE000FE3, 0, 1); cyc();
        req(0, 3'd4, 32'h00000037, 32'h00001001, 5'd0);
        lit("b_odd", 32'h000000E3, 1, 1); cyc();
        in_valid = 1'b0; lit("u_low", 32'h00001037, 1, 1); cyc();

        req(1, 3'd0, 32'h0, 32'h12345FFF, 5'd5); cyc();
        in_valid = 1'b0; lit("li_lui", 32'h123462B7, 0, 0);
        chk("li_mid.in_ready", 32'(in_ready), 32'd0); cyc();
        lit("li_addi", 32'hFFF28293, 0, 1); cyc();

        req(1, 3'd0, 32'h0, 32'h00000005, 5'd1); cyc();
        req(1, 3'd0, 32'h0, 32'h00001000, 5'd1);
        lit("li_small", 32'h00500093, 0, 1); cyc();
        in_valid = 1'b0; lit("li_lui_only", 32'h000010B7, 0, 1); cyc();

        req(1, 3'd0, 32'h0, 32'h12345FFF, 5'd5); cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lit("bp_hold", 32'h123462B7, 0, 0);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        lit("bp_lui", 32'h123462B7, 0, 0); cyc();
        lit("bp_addi", 32'hFFF28293, 0, 1); cyc();

        req(1, 3'd0, 32'h0, 32'h12345FFF, 5'd5); cyc();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst2nd.valid", 32'(out_valid), 32'd0);
        chk("rst2nd.in_ready", 32'(in_ready), 32'd1);
        cyc();
        cyc();

        req(0, 3'd6, 32'h12345678, 32'h0, 5'd0); cyc();
        in_valid = 1'b0; lit("illegal", 32'h12345678, 1, 1); cyc();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] v;
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 6000)) - 32'd3000;
                2: v = $urandom & 32'hFFFFF000;
                3: v = $urandom & 32'h00000FFF;
                default: v = 32'($signed(21'($urandom)));
            endcase
            req(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom, v, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 8 && q.size() != 0; n++) cyc();
        cyc();
        chk("drain.pending", 32'(q.size()), 32'd0);
        chk("drain.valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
